// File: rtl/store_queue_pkg.sv
// Shared types for the store queue: entry layout, lookup packets, access sizes
// and the store lane-alignment helper.
package store_queue_pkg;
    localparam int SQ_IDX_W = 3;
    localparam int XLEN     = 32;
    localparam int SQ_DEPTH = 1 << SQ_IDX_W;
    localparam int CNT_W    = SQ_IDX_W + 1;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic            valid;
        logic            addr_valid;
        logic [XLEN-1:2] word_addr;
        logic [3:0]      bytes;
        logic [XLEN-1:0] data;
    } sq_entry_t;

    typedef struct packed {
        logic [XLEN-1:0]     addr;
        logic [SQ_IDX_W-1:0] tail_pos;
    } load_sq_packet_t;

    typedef struct packed {
        logic [3:0]      usebytes;
        logic [XLEN-1:0] data;
        logic            stall;
    } sq_load_packet_t;

    typedef struct packed {
        logic [3:0]      bytes;
        logic [XLEN-1:0] data;
    } store_lane_t;

    // Places the low bytes of rs2 into word lanes; misaligned half/word give no lanes.
    function automatic store_lane_t align_store(input logic [1:0] offset,
                                                input logic [XLEN-1:0] data,
                                                input logic [1:0] size);
        store_lane_t lane;
        lane = '0;
        case (size)
            BYTE: begin
                lane.bytes = 4'b0001 << offset;
                lane.data  = {{(XLEN-8){1'b0}}, data[7:0]} << {offset, 3'b000};
            end
            HALF: begin
                if (!offset[0]) begin
                    lane.bytes = offset[1] ? 4'b1100 : 4'b0011;
                    lane.data  = {{(XLEN-16){1'b0}}, data[15:0]} << {offset, 3'b000};
                end
            end
            WORD: begin
                if (offset == 2'd0) begin
                    lane.bytes = 4'b1111;
                    lane.data  = data;
                end
            end
            default: lane = '0;
        endcase
        return lane;
    endfunction
endpackage

// File: rtl/store_queue_forward.sv
// Store-to-load forwarding: selects stores older than the load and merges
// matching bytes with the youngest store winning each byte lane.
module sq_forward
    import store_queue_pkg::*;
(
    input  sq_entry_t           entries [SQ_DEPTH],
    input  logic [SQ_IDX_W-1:0] head,
    input  load_sq_packet_t     lookup,
    output sq_load_packet_t     result
);
    logic [SQ_IDX_W-1:0] span;
    logic [SQ_IDX_W-1:0] slot;
    logic [SQ_DEPTH-1:0] older;
    logic [SQ_DEPTH-1:0] unresolved;
    logic [SQ_DEPTH-1:0] hit;
    logic                unused_low_addr;

    assign span            = lookup.tail_pos - head;
    assign unused_low_addr = &{1'b0, lookup.addr[1:0]};

    for (genvar gi = 0; gi < SQ_DEPTH; gi++) begin : g_slot
        logic [SQ_IDX_W-1:0] age;
        assign age            = SQ_IDX_W'(gi) - head;
        assign older[gi]      = (age < span) && entries[gi].valid;
        assign unresolved[gi] = older[gi] && !entries[gi].addr_valid;
        assign hit[gi]        = older[gi] && entries[gi].addr_valid &&
                                (entries[gi].word_addr == lookup.addr[XLEN-1:2]);
    end

    // Older slots form a prefix of the age order, so walking from head is oldest-first.
    always_comb begin
        result = '0;
        slot   = head;
        if (|unresolved) begin
            result.stall = 1'b1;
        end else begin
            for (int k = 0; k < SQ_DEPTH; k++) begin
                slot = head + SQ_IDX_W'(k);
                if (hit[slot]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (entries[slot].bytes[b]) begin
                            result.usebytes[b]     = 1'b1;
                            result.data[8*b +: 8] = entries[slot].data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: rtl/store_queue.sv
// Circular store queue: program-order allocation, execute-time fill, in-order
// drain to the dcache at retirement, and store-to-load forwarding lookup.
module store_queue
    import store_queue_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                squash,
    input  logic                dispatch_valid,
    output logic                sq_full,
    output logic [SQ_IDX_W-1:0] sq_tail,
    input  logic                exec_valid,
    input  logic [SQ_IDX_W-1:0] exec_idx,
    input  logic [XLEN-1:0]     exec_addr,
    input  logic [XLEN-1:0]     exec_data,
    input  logic [1:0]          exec_size,
    input  logic                retire_valid,
    output logic                cache_wr_en,
    output logic [XLEN-1:0]     cache_wr_addr,
    output logic [XLEN-1:0]     cache_wr_data,
    output logic [3:0]          cache_wr_bytes,
    input  logic [XLEN-1:0]     lookup_addr,
    input  logic [SQ_IDX_W-1:0] lookup_tail,
    output logic [3:0]          lookup_usebytes,
    output logic [XLEN-1:0]     lookup_data,
    output logic                lookup_stall
);
    sq_entry_t           entries [SQ_DEPTH];
    sq_entry_t           head_entry;
    store_lane_t         exec_lane;
    logic [SQ_IDX_W-1:0] head_reg, head_next;
    logic [SQ_IDX_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic                do_dispatch, do_exec, do_retire;
    load_sq_packet_t     lookup_req;
    sq_load_packet_t     lookup_resp;

    assign head_entry  = entries[head_reg];
    assign sq_full     = (count_reg == CNT_W'(SQ_DEPTH - 1));
    assign sq_tail     = tail_reg;
    assign do_retire   = retire_valid && head_entry.valid && head_entry.addr_valid;
    assign do_dispatch = dispatch_valid && !sq_full && !squash;
    assign do_exec     = exec_valid && entries[exec_idx].valid && !squash;
    assign exec_lane   = align_store(exec_addr[1:0], exec_data, exec_size);

    for (genvar gi = 0; gi < SQ_DEPTH; gi++) begin : g_entry
        sq_entry_t entry_reg;
        always_ff @(posedge clock) begin
            if (reset || squash) begin
                entry_reg <= '0;
            end else if (do_retire && head_reg == SQ_IDX_W'(gi)) begin
                entry_reg <= '0;
            end else if (do_dispatch && tail_reg == SQ_IDX_W'(gi)) begin
                entry_reg       <= '0;
                entry_reg.valid <= 1'b1;
            end else if (do_exec && exec_idx == SQ_IDX_W'(gi)) begin
                entry_reg.addr_valid <= 1'b1;
                entry_reg.word_addr  <= exec_addr[XLEN-1:2];
                entry_reg.bytes      <= exec_lane.bytes;
                entry_reg.data       <= exec_lane.data;
            end
        end
        assign entries[gi] = entry_reg;
    end

    // A retire coincident with squash still drains, and the flushed tail follows the new head.
    always_comb begin
        head_next  = head_reg + SQ_IDX_W'(do_retire);
        tail_next  = tail_reg + SQ_IDX_W'(do_dispatch);
        count_next = count_reg;
        if (squash) begin
            tail_next  = head_next;
            count_next = '0;
        end else if (do_dispatch && !do_retire) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!do_dispatch && do_retire) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            cache_wr_en    <= 1'b0;
            cache_wr_addr  <= '0;
            cache_wr_data  <= '0;
            cache_wr_bytes <= '0;
        end else begin
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            count_reg   <= count_next;
            cache_wr_en <= do_retire;
            if (do_retire) begin
                cache_wr_addr  <= {head_entry.word_addr, 2'b00};
                cache_wr_data  <= head_entry.data;
                cache_wr_bytes <= head_entry.bytes;
            end
        end
    end

    assign lookup_req = {lookup_addr, lookup_tail};

    sq_forward u_forward (
        .entries (entries),
        .head    (head_reg),
        .lookup  (lookup_req),
        .result  (lookup_resp)
    );

    assign lookup_usebytes = lookup_resp.usebytes;
    assign lookup_data     = lookup_resp.data;
    assign lookup_stall    = lookup_resp.stall;
endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Circular buffer of in-flight stores, allocated in program order at dispatch and filled by the store FU at execute.
- Drained in order to the data cache at ROB retirement.
- Serves the load FU's store-to-load lookup: returns forwarded bytes and data for one word, or stalls the load while any older store address is unresolved.
- Sits between dispatch/ROB, the store FU, the load FU and the dcache write port.

Parameters:
- SQ_IDX_W, 3: index/pointer width (matches `LSQ). Depth = 2**SQ_IDX_W = 8 slots, usable capacity 7.
- XLEN, 32: address/data width.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  flush all non-retired entries
- dispatch_valid  in  1  allocate one entry at tail this cycle
- sq_full  out  1  count == DEPTH-1; dispatch must not assert dispatch_valid
- sq_tail  out  SQ_IDX_W  current tail; dispatch stamps it into loads and stores
- exec_valid  in  1  store FU result valid
- exec_idx  in  SQ_IDX_W  entry being filled
- exec_addr  in  XLEN  byte address
- exec_data  in  XLEN  rs2 value, unaligned (low bytes)
- exec_size  in  2  0=byte, 1=half, 2=word
- retire_valid  in  1  ROB commits the head store
- cache_wr_en  out  1  registered dcache write strobe
- cache_wr_addr  out  XLEN  word-aligned address
- cache_wr_data  out  XLEN  aligned data
- cache_wr_bytes  out  4  byte enables
- lookup_addr  in  XLEN  load word address, bits[1:0]=0
- lookup_tail  in  SQ_IDX_W  load's stamped tail
- lookup_usebytes  out  4  bytes supplied by older stores
- lookup_data  out  XLEN  forwarded bytes in word position; others 0
- lookup_stall  out  1  an older store has unknown address

Behaviour:
- Entry fields: valid, addr_valid, word_addr[XLEN-1:2], bytes[3:0], data[XLEN-1:0]. Registers: head, tail, count[SQ_IDX_W:0].
- Reset: all entries cleared; head=tail=count=0; cache_wr_en=0, cache_wr_addr/data/bytes=0. Reset dominates squash and all other inputs.
- Dispatch:
  - Entry[tail] becomes valid=1, addr_valid=0.
  - tail<=tail+1 with natural wrap; count+1.
  - One slot is always left empty, so tail==head only when empty.
  - dispatch_valid while sq_full: ignored, no state change.
- Execute: entry[exec_idx] gets addr_valid=1, word_addr, and bytes/data aligned by exec_addr[1:0]:
  - byte: bytes=1<<a, data byte at position a.
  - half: a in {0,2}, bytes=0011 or 1100.
  - word: 1111.
  - Misaligned half/word: bytes=0, no write.
  - exec to an invalid entry: ignored.
- Retire (retire_valid, head valid and addr_valid):
  - Next cycle cache_wr_en=1 with that entry's fields.
  - Entry cleared; head+1; count-1.
  - Otherwise cache_wr_en=0. retire_valid when empty: ignored.
- Simultaneous dispatch+retire: both pointers advance, count unchanged. Execute of the entry retiring this cycle cannot occur (ROB guarantees).
- Squash: tail<=head, count<=0, all entries invalidated. A retire in the same cycle still completes first: cache write issued, head+1, and tail set to the new head. Dispatch/exec that cycle dropped.
- Lookup (combinational, same cycle):
  - Older set = entries from head up to lookup_tail-1, wrapping; empty if lookup_tail==head.
  - lookup_stall=1 if any older entry has addr_valid=0; usebytes/data then 0.
  - Else walk oldest to youngest; each entry with matching word_addr overwrites its bytes in data and ORs into usebytes. Youngest wins per byte.
  - An exec write becomes visible to lookup the cycle after exec_valid.

Decomposition:
- Shared package: SQ_ENTRY struct; LOAD_SQ_PACKET (addr, tail_pos) and SQ_LOAD_PACKET (usebytes, data, stall) driven onto lookup ports; MEM_SIZE enum (BYTE, HALF, WORD).
- One sub-module, sq_forward: purely combinational older-set mask + youngest-wins byte merge, taking the entry array, head and lookup_tail.

Test Plan:
- Reset, then dispatch 7 stores -> sq_tail=7, sq_full=1; 8th dispatch ignored, tail stays 7.
- Dispatch idx0; lookup_tail=1, addr 0x100 -> stall=1; exec idx0 word 0x100 data 0xDEADBEEF -> next cycle stall=0, usebytes=1111, data=0xDEADBEEF.
- Store byte 0x101 data 0xAA (idx0), store word 0x100 0x11223344 (idx1), lookup_tail=2 -> usebytes=1111, data=0x11223344. Same stores with lookup_tail=1 -> usebytes=0010, data=0x0000AA00.
- Retire idx0 (half 0x202, data 0x5566) -> next cycle cache_wr_en=1, addr=0x200, bytes=1100, data=0x55660000; head=1.
- Wrap: head=6, tail=2, exec all entries; lookup_tail=1 with entries 6 and 0 matching -> entry 0 bytes override entry 6.
- Squash with 3 entries plus same-cycle retire -> cache write of head, count=0, tail==head, sq_full=0.
